// File: rtl/fp_cfg_pkg.sv
// Shared definitions for the configurable bit-vector filter pipeline:
// pair op encoding, config word layout and address decode helpers.
package fp_cfg_pkg;

   typedef enum logic [2:0] {
      OP_PASS = 3'd0,
      OP_AND  = 3'd1,
      OP_OR   = 3'd2,
      OP_XOR  = 3'd3,
      OP_ANDN = 3'd4,
      OP_ZERO = 3'd5
   } op_e;

   localparam int CFG_DATA_W = 8;

   // Addresses [0, lanes) hold crossbar selects, [lanes, lanes + lanes/2) hold pair ops.
   function automatic logic is_sel_addr(input int addr, input int lanes);
      return addr < lanes;
   endfunction

   function automatic logic is_op_addr(input int addr, input int lanes);
      return (addr >= lanes) && (addr < lanes + lanes / 2);
   endfunction

   function automatic int op_pair(input int addr, input int lanes);
      return addr - lanes;
   endfunction

   // Binary ops need both operands valid; unary ones follow the own lane.
   function automatic logic pair_valid(input logic [2:0] op, input logic wa, input logic wb);
      case (op)
         OP_AND, OP_OR, OP_XOR, OP_ANDN: return wa & wb;
         default:                        return wa;
      endcase
   endfunction

endpackage

// File: rtl/fp_cfg_stage.sv
// One pipeline stage: two config banks selected by the datum's epoch tag,
// a full lane crossbar, the pairwise filter ALU and the stage registers.
module fp_cfg_stage import fp_cfg_pkg::*; #(
   parameter int LANES  = 8,
   parameter int BV_W   = 128,
   parameter int CFG_AW = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 wr_en,
   input  logic                 wr_bank,
   input  logic [CFG_AW-1:0]    cfg_addr,
   input  logic [5:0]           cfg_data,
   input  logic [BV_W-1:0]      src_data [LANES],
   input  logic [LANES-1:0]     src_vld,
   input  logic                 src_epoch,
   output logic [BV_W-1:0]      data_p0 [LANES],
   output logic [LANES-1:0]     vld_p0,
   output logic                 epoch_p0
);

   localparam int LANES_LOG = $clog2(LANES);
   localparam int PAIRS     = LANES / 2;

   logic [LANES_LOG-1:0] sel_bank [2][LANES];
   logic [2:0]           opa_bank [2][PAIRS];
   logic [2:0]           opb_bank [2][PAIRS];

   logic [BV_W-1:0]      y [LANES];
   logic [LANES-1:0]     w;
   logic [BV_W-1:0]      z [LANES];
   logic [LANES-1:0]     vz;
   int                   addr_i;

   assign addr_i = int'(cfg_addr);

   function automatic logic [BV_W-1:0] pair_op(input logic [2:0] op,
                                               input logic [BV_W-1:0] a,
                                               input logic [BV_W-1:0] b);
      case (op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_ANDN: return a & ~b;
         OP_ZERO: return '0;
         default: return a;
      endcase
   endfunction

   // Config banks: bank index is chosen by the top (always the shadow bank).
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < LANES; l++) sel_bank[b][l] <= LANES_LOG'(l);
            for (int p = 0; p < PAIRS; p++) begin
               opa_bank[b][p] <= OP_PASS;
               opb_bank[b][p] <= OP_PASS;
            end
         end
      end else if (wr_en) begin
         for (int l = 0; l < LANES; l++)
            if (is_sel_addr(addr_i, LANES) && addr_i == l)
               sel_bank[wr_bank][l] <= cfg_data[LANES_LOG-1:0];
         for (int p = 0; p < PAIRS; p++)
            if (is_op_addr(addr_i, LANES) && op_pair(addr_i, LANES) == p) begin
               opa_bank[wr_bank][p] <= cfg_data[2:0];
               opb_bank[wr_bank][p] <= cfg_data[5:3];
            end
      end
   end

   always_comb begin
      y = '{default: '0};
      w = '0;
      for (int l = 0; l < LANES; l++) begin
         y[l] = src_data[sel_bank[src_epoch][l]];
         w[l] = src_vld[sel_bank[src_epoch][l]];
      end
   end

   always_comb begin
      z  = '{default: '0};
      vz = '0;
      for (int p = 0; p < PAIRS; p++) begin
         z[2*p]    = pair_op(opa_bank[src_epoch][p], y[2*p], y[2*p+1]);
         z[2*p+1]  = pair_op(opb_bank[src_epoch][p], y[2*p+1], y[2*p]);
         vz[2*p]   = pair_valid(opa_bank[src_epoch][p], w[2*p], w[2*p+1]);
         vz[2*p+1] = pair_valid(opb_bank[src_epoch][p], w[2*p+1], w[2*p]);
      end
   end

   // ---- stage register boundary ----
   always_ff @(posedge clk) begin
      if (rst) begin
         data_p0  <= '{default: '0};
         vld_p0   <= '0;
         epoch_p0 <= 1'b0;
      end else if (en) begin
         data_p0  <= z;
         vld_p0   <= vz;
         epoch_p0 <= src_epoch;
      end
   end

endmodule

// File: rtl/fp_cfg_pipe.sv
// Configurable bit-vector filter pipeline: STAGES crossbar+pair-ALU stages with
// per-lane valids, global stall and double-banked, epoch-tagged configuration.
module fp_cfg_pipe import fp_cfg_pkg::*; #(
   parameter int  LANES      = 8,
   parameter int  STAGES     = 4,
   parameter int  BV_W       = 128,
   localparam int LANES_LOG  = $clog2(LANES),
   localparam int STAGES_LOG = (STAGES > 1) ? $clog2(STAGES) : 1,
   localparam int CFG_AW     = LANES_LOG + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [BV_W-1:0]       in [LANES],
   input  logic [LANES-1:0]      valid_in,
   input  logic                  cfg_we,
   input  logic [STAGES_LOG-1:0] cfg_stage,
   input  logic [CFG_AW-1:0]     cfg_addr,
   input  logic [CFG_DATA_W-1:0] cfg_data,
   input  logic                  cfg_commit,
   output logic                  cfg_ready,
   output logic                  epoch,
   output logic [BV_W-1:0]       out [LANES],
   output logic [LANES-1:0]      valid_out
);

   localparam int DRAIN_W = $clog2(STAGES + 1);

   logic [BV_W-1:0]    stg_data  [STAGES+1][LANES];
   logic [LANES-1:0]   stg_vld   [STAGES+1];
   logic               stg_epoch [STAGES+1];
   logic [DRAIN_W-1:0] drain_cnt;
   logic               unused_cfg_bits;

   assign unused_cfg_bits = ^cfg_data[CFG_DATA_W-1:6];

   assign stg_data[0]  = in;
   assign stg_vld[0]   = valid_in;
   assign stg_epoch[0] = epoch;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic wr_en;
      assign wr_en = cfg_we && cfg_ready && (int'(cfg_stage) == s);

      fp_cfg_stage #(
         .LANES  (LANES),
         .BV_W   (BV_W),
         .CFG_AW (CFG_AW)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .en        (en),
         .wr_en     (wr_en),
         .wr_bank   (~epoch),
         .cfg_addr  (cfg_addr),
         .cfg_data  (cfg_data[5:0]),
         .src_data  (stg_data[s]),
         .src_vld   (stg_vld[s]),
         .src_epoch (stg_epoch[s]),
         .data_p0   (stg_data[s+1]),
         .vld_p0    (stg_vld[s+1]),
         .epoch_p0  (stg_epoch[s+1])
      );
   end

   assign out       = stg_data[STAGES];
   assign valid_out = stg_vld[STAGES];

   // Commit swaps banks, then the old bank stays locked until every datum tagged
   // with it has left the pipe (STAGES enabled edges).
   always_ff @(posedge clk) begin
      if (rst) begin
         epoch     <= 1'b0;
         cfg_ready <= 1'b1;
         drain_cnt <= '0;
      end else if (cfg_commit && cfg_ready) begin
         epoch     <= ~epoch;
         cfg_ready <= 1'b0;
         drain_cnt <= DRAIN_W'(STAGES);
      end else if (!cfg_ready && en) begin
         drain_cnt <= drain_cnt - 1'b1;
         if (drain_cnt == DRAIN_W'(1)) cfg_ready <= 1'b1;
      end
   end

endmodule

// File: doc/fp_cfg_pipe.md
Name: fp_cfg_pipe

Overview:
- Parametrised bit-vector filter pipeline: LANES vectors of BV_W bits flow through STAGES registered stages.
- Each stage does two things in order:
  - a programmable lane permutation (full crossbar select per lane);
  - a pairwise bitwise filter op on lane pairs (2p, 2p+1).
- Successor to the fixed-size filter pipelines, with three additions:
  - per-lane valid propagation;
  - global stall (en);
  - double-banked runtime configuration with epoch tagging, so every datum sees one consistent configuration across all stages.

Parameters:
- LANES, 8: lane count; power of 2, 2..64.
- STAGES, 4: pipeline depth; at least 1.
- BV_W, 128: bit-vector width.
- LANES_LOG, $clog2(LANES): derived, not overridable.
- STAGES_LOG, max(1,$clog2(STAGES)): derived.
- CFG_AW, LANES_LOG+1: derived, config address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  pipeline advance; 0 holds every data/valid/epoch register
- in  in  [BV_W-1:0] x LANES (unpacked)  input vectors
- valid_in  in  1 x LANES  per-lane valid
- cfg_we  in  1  config write strobe
- cfg_stage  in  STAGES_LOG  target stage
- cfg_addr  in  CFG_AW  word select within stage
- cfg_data  in  8  write data
- cfg_commit  in  1  swap shadow/active bank
- cfg_ready  out  1  shadow bank writable, commit accepted
- epoch  out  1  current input epoch (active bank index)
- out  out  [BV_W-1:0] x LANES  result vectors
- valid_out  out  1 x LANES  result valids

Behaviour:
- Reset: applies one clk edge after rst=1 and clears all of the following.
  - out=0, valid_out=0, all stage registers 0.
  - epoch=0, cfg_ready=1, drain counter 0.
  - Both banks: sel[l]=l, opA=opB=PASS.
- Per-stage datapath, input x/v with epoch tag e, using bank e:
  - Crossbar: y[l]=x[sel[l]], w[l]=v[sel[l]].
  - Pair p, lane 2p: op(opA, y[2p], y[2p+1]).
  - Pair p, lane 2p+1: op(opB, y[2p+1], y[2p]).
- op codes, with a = own lane, b = partner:
  - 0 PASS = a
  - 1 AND = a&b
  - 2 OR = a|b
  - 3 XOR = a^b
  - 4 ANDN = a&~b
  - 5 ZERO = 0
  - 6/7 = PASS
- Valid rules:
  - Binary ops (1-4): valid = wa&wb.
  - PASS/ZERO: valid = wa.
  - Invalid lanes still carry data; the data value is don't-care.
- Timing:
  - Stage s registers on en=1; stage 0 samples in/valid_in/epoch.
  - Latency is exactly STAGES enabled edges.
  - out/valid_out are the last stage registers.
- Epoch tagging:
  - The epoch bit is registered alongside each stage's data.
  - Stage s selects its bank by its incoming tag, not by the global epoch.
- Config writes:
  - Accepted when cfg_we & cfg_ready & cfg_stage<STAGES; they target bank !epoch of cfg_stage.
  - cfg_addr<LANES: sel[cfg_addr] = cfg_data[LANES_LOG-1:0].
  - LANES<=cfg_addr<LANES+LANES/2: pair cfg_addr-LANES gets opA=cfg_data[2:0], opB=cfg_data[5:3].
  - Other addresses, or writes with cfg_ready=0: ignored, no state change.
  - Writes do not depend on en.
- Commit:
  - cfg_commit with cfg_ready=1 toggles epoch at the edge.
  - It sets cfg_ready=0 and loads the drain counter with STAGES.
  - Same-cycle cfg_we and cfg_commit: the write lands in the shadow bank, then the swap happens, so the write is included.
  - Commit with cfg_ready=0 is ignored.
- Drain:
  - The counter decrements on each en=1 edge.
  - cfg_ready returns to 1 on the edge where it reaches 0.
  - With en=0 the counter holds, because old-epoch data is still in flight.
- rst mid-operation: the reset state above applies at once, in-flight data is discarded and pending drain is cancelled.

Decomposition:
- Package fp_cfg_pkg holds:
  - op enum: PASS, AND, OR, XOR, ANDN, ZERO;
  - CFG_DATA_W=8;
  - address decode helpers.
- Sub-module fp_cfg_stage: one stage = two config banks + crossbar + pair ALU + registers. The top generates STAGES instances plus the epoch/drain control.

Test Plan:
- Reset then identity config, LANES=8, STAGES=4, en=1: in[l]=l*0x11, valid_in all 1 -> identical out and valid_out after exactly 4 edges.
- Shadow write stage0: sel = reverse (sel[l]=7-l), pair0 data 0x01 (opA=AND), then commit; input lane0=0xF0, lane7=0x3C -> before commit unchanged; after commit out[0]=0x3C&lane6 value per reversed map; epoch=1; cfg_ready low 4 enabled edges.
- Commit while 3 old-epoch items in flight: the old items exit using old ops, the first new-epoch item uses new ops, with no mixed-config output.
- en=0 for 5 cycles mid-drain: out/valid_out held, cfg_ready stays 0; it resumes and rises after the remaining enabled edges.
- Binary-op valid: valid_in[1]=0 with pair0 opA=XOR -> valid_out[0]=0; same with PASS -> valid_out[0]=1.
- Edge cases: cfg_we at cfg_ready=0, cfg_stage=STAGES, cfg_addr=LANES+LANES/2 -> all ignored (readback via datapath unchanged); rst asserted mid-drain -> cfg_ready=1, epoch=0, out=0 next edge.
